// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared adder widths, id-width helper and response-entry field offsets
package adder_sched_pkg;
  localparam int ADD_OPW = 1028;
  localparam int ADD_SUMW = ADD_OPW + 1;
  localparam int ADDER_LATENCY = 1;
  localparam int RSP_SUM_LSB = 0;
  localparam int RSP_ID_LSB = ADD_SUMW;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int rsp_id_lsb(input int opw);
    return opw + 1;
  endfunction
endpackage

// File: rtl/adder_sched_rr_arb.sv
// adder_sched_rr_arb: round-robin arbiter with grant enable and pointer update
module adder_sched_rr_arb
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDW = id_w(NREQ)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NREQ-1:0] req,
  input  logic            gnt_en,
  input  logic            upd,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] j;
  // scan from farthest to nearest after ptr so the nearest requester wins
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j = '0;
    for (int k = NREQ; k > 0; k--) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        gnt_idx = j;
        gnt_any = 1'b1;
      end
    end
  end
  assign gnt = (gnt_en && gnt_any) ? (NREQ'(1) << gnt_idx) : '0;
  // pointer follows the last granted index so requester 0 leads after reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr <= IDW'(NREQ - 1);
    else if (upd) ptr <= gnt_idx;
  end
endmodule

// File: rtl/adder_sched.sv
// adder_sched: credit-based round-robin scheduler for a shared 1-cycle adder; ADDER_SCHED_PERF_EN adds perf counters
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int OPW = ADD_OPW,
  parameter int RSP_DEPTH = 2,
  localparam int IDW = id_w(NREQ),
  localparam int SW = OPW + 1,
  localparam int AW = $clog2(RSP_DEPTH),
  localparam int EW = IDW + SW
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [OPW-1:0]      add_in_a,
  output logic [OPW-1:0]      add_in_b,
  input  logic [SW-1:0]       add_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [SW-1:0]       rsp_sum
`ifdef ADDER_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_stall
`endif
);
  logic [IDW-1:0] gidx;
  logic gany, credit, pop, fire;
  logic s1_valid;
  logic [IDW-1:0] s1_id;
  logic [EW-1:0] mem [RSP_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  assign pop = rsp_valid & rsp_ready;
  assign credit = (int'(count) + int'(s1_valid) - int'(pop)) < RSP_DEPTH;
  assign fire = gany & credit;
  adder_sched_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk(clk),
    .resetn(resetn),
    .req(req_valid),
    .gnt_en(credit),
    .upd(fire),
    .gnt(req_ready),
    .gnt_idx(gidx),
    .gnt_any(gany)
  );
  assign add_in_a = fire ? req_a[gidx*OPW +: OPW] : '0;
  assign add_in_b = fire ? req_b[gidx*OPW +: OPW] : '0;
  assign rsp_valid = count != '0;
  assign rsp_id = mem[rp][rsp_id_lsb(OPW) +: IDW];
  assign rsp_sum = mem[rp][RSP_SUM_LSB +: SW];
  // track the single op in flight through the adder pipeline stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_id <= '0;
    end else begin
      s1_valid <= fire;
      s1_id <= gidx;
    end
  end
  // fifo pointers and occupancy; push is unconditional because credit reserved the slot
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(s1_valid);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(s1_valid) - (AW+1)'(pop);
    end
  end
  // capture the adder result together with its requester id
  always_ff @(posedge clk) begin
    if (s1_valid) mem[wp] <= {s1_id, add_result};
  end
`ifdef ADDER_SCHED_PERF_EN
  // saturating transfer and credit-stall counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_issued <= '0;
      perf_stall <= '0;
    end else begin
      if (fire && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
      if (|req_valid && !credit && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: scoreboard bench for adder_sched with directed vectors
module tb_adder_sched;
  import adder_sched_pkg::*;
  localparam int W = ADD_OPW;
  typedef struct packed {
    logic id;
    logic [W:0] sum;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [2*W-1:0] req_a = '0, req_b = '0;
  logic [W-1:0] add_in_a, add_in_b;
  logic [W:0] add_result;
  logic rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [W:0] rsp_sum;
  logic [3:0] r4v = '0, r4r;
  logic [31:0] r4a = '0, r4b = '0;
  logic [7:0] a4a, a4b;
  logic [8:0] r4res, r4sum;
  logic r4rv, r4rr = 1'b0;
  logic [1:0] r4id;
`ifdef ADDER_SCHED_PERF_EN
  logic [31:0] perf_issued, perf_stall, p4i, p4s;
`endif
  exp_t q[$];
  int n_chk = 0, n_fail = 0, n_pop = 0, exp_iss = 0, exp_stl = 0;
  adder_sched dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_in_a(add_in_a), .add_in_b(add_in_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum)
`ifdef ADDER_SCHED_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );
  adder_sched #(.NREQ(4), .OPW(8), .RSP_DEPTH(2)) dut4 (
    .clk(clk), .resetn(resetn), .req_valid(r4v), .req_a(r4a), .req_b(r4b),
    .req_ready(r4r), .add_in_a(a4a), .add_in_b(a4b), .add_result(r4res),
    .rsp_valid(r4rv), .rsp_ready(r4rr), .rsp_id(r4id), .rsp_sum(r4sum)
`ifdef ADDER_SCHED_PERF_EN
    , .perf_issued(p4i), .perf_stall(p4s)
`endif
  );
  always @(posedge clk) add_result <= {1'b0, add_in_a} + {1'b0, add_in_b};
  always @(posedge clk) r4res <= {1'b0, a4a} + {1'b0, a4b};
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_sum(input string nm, input logic [W:0] act, input logic [W:0] exp);
    logic [1087:0] ga, ea;
    int k;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      ga = 1088'(act);
      ea = 1088'(exp);
      k = 0;
      for (int w = 0; w < 17; w++) if (ga[w*64 +: 64] !== ea[w*64 +: 64]) k = w;
      $display("FAIL %s word %0d: got %h expected %h", nm, k, ga[k*64 +: 64], ea[k*64 +: 64]);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (resetn && rsp_valid && rsp_ready) begin
      n_pop++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d, expected no response", rsp_id);
      end else begin
        e = q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk_sum("rsp_sum", rsp_sum, e.sum);
      end
    end
  end
  task automatic rand_ops();
    for (int w = 0; w < 65; w++) begin
      req_a = {req_a[2*W-33:0], 32'($urandom())};
      req_b = {req_b[2*W-33:0], 32'($urandom())};
    end
  endtask
  task automatic step(input logic [1:0] vld, input logic rr, input logic [1:0] er, input string nm, input bit rnd);
    exp_t e;
    int i;
    @(posedge clk);
    #1;
    req_valid = vld;
    rsp_ready = rr;
    if (rnd) rand_ops();
    @(negedge clk);
    chk(nm, 64'(req_ready), 64'(er));
    if (er != 2'b00) begin
      i = er[1] ? 1 : 0;
      e.id = er[1];
      e.sum = {1'b0, req_a[i*W +: W]} + {1'b0, req_b[i*W +: W]};
      q.push_back(e);
      exp_iss++;
    end else if (vld != 2'b00) exp_stl++;
  endtask
  task automatic drain(input int n, input string nm);
    repeat (n) step(2'b00, 1'b1, 2'b00, "drain_grant", 1'b0);
    @(posedge clk);
    #1;
    chk(nm, 64'(q.size()), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
  initial begin
    int p0;
    logic [3:0] eg [3];
    int ei [3];
    int es [3];
    eg = '{4'b0100, 4'b1000, 4'b0100};
    ei = '{2, 3, 2};
    es = '{283, 299, 283};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    req_a[W-1:0] = W'(1);
    req_b[W-1:0] = '1;
    step(2'b01, 1'b1, 2'b01, "t1_grant", 1'b0);
    step(2'b00, 1'b1, 2'b00, "t1_idle", 1'b0);
    chk("t1_lat1_valid", 64'(rsp_valid), 64'd0);
    step(2'b00, 1'b1, 2'b00, "t1_idle", 1'b0);
    chk("t1_lat2_valid", 64'(rsp_valid), 64'd1);
    chk_sum("t1_sum_hand", rsp_sum, {1'b1, {W{1'b0}}});
    drain(2, "t1_drained");
    p0 = n_pop;
    for (int k = 0; k < 6; k++) step(2'b11, 1'b1, (k % 2) ? 2'b01 : 2'b10, "t2_grant", 1'b1);
    drain(4, "t2_drained");
    chk("t2_pops", 64'(n_pop - p0), 64'd6);
    step(2'b11, 1'b0, 2'b10, "t3_fill", 1'b1);
    step(2'b11, 1'b0, 2'b01, "t3_fill", 1'b1);
    step(2'b11, 1'b0, 2'b00, "t3_block", 1'b1);
    step(2'b11, 1'b0, 2'b00, "t3_block", 1'b1);
    chk("t3_full_valid", 64'(rsp_valid), 64'd1);
    step(2'b11, 1'b1, 2'b10, "t3_resume", 1'b1);
    step(2'b11, 1'b1, 2'b01, "t3_stream", 1'b1);
    step(2'b11, 1'b1, 2'b10, "t3_stream", 1'b1);
    drain(5, "t3_drained");
    step(2'b11, 1'b0, 2'b01, "t4_issue", 1'b1);
    step(2'b11, 1'b0, 2'b10, "t4_issue", 1'b1);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    #1;
    resetn = 1'b0;
    #1;
    chk("t4_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    q.delete();
    exp_iss = 0;
    exp_stl = 0;
    @(negedge clk);
    resetn = 1'b1;
    p0 = n_pop;
    step(2'b11, 1'b1, 2'b01, "t4_first_grant", 1'b1);
    step(2'b00, 1'b1, 2'b00, "t4_idle", 1'b0);
    drain(4, "t4_drained");
    chk("t4_pops", 64'(n_pop - p0), 64'd1);
`ifdef ADDER_SCHED_PERF_EN
    chk("perf_issued", 64'(perf_issued), 64'(exp_iss));
    chk("perf_stall", 64'(perf_stall), 64'(exp_stl));
`endif
    r4a = {8'd49, 8'd33, 8'd17, 8'd1};
    r4b = {4{8'd250}};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      r4v = (k < 3) ? 4'b1100 : 4'b0000;
      r4rr = 1'b1;
      @(negedge clk);
      chk("t5_grant", 64'(r4r), 64'((k < 3) ? eg[k] : 4'b0000));
      if (k >= 2) begin
        chk("t5_rsp_valid", 64'(r4rv), 64'd1);
        chk("t5_rsp_id", 64'(r4id), 64'(ei[k-2]));
        chk("t5_rsp_sum", 64'(r4sum), 64'(es[k-2]));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
